// File: rtl/fetch_unit.sv
// Generic FIFO with a synchronous flush. Data reaches the head one cycle after it is pushed.
// The caller handles backpressure: pushing into a full FIFO is legal only in a cycle that also pops.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// Fetch stage: in-order requests to variable-latency imem, DEPTH-entry prefetch queue toward decode.
// Response-to-instr_valid latency is at least one cycle; requests stop when queued + outstanding hits DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);
    localparam int          CW     = $clog2(DEPTH + 1);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [CW-1:0] count, outstanding, outstanding_nxt;
    logic [CW-1:0] drop_cnt, drop_cnt_nxt;
    logic          halted_nxt;
    logic          redir, accept, pop, push;
    logic [31:0]   resp_pc;
    logic [63:0]   head;

    // Redirects are ignored once halted; otherwise they override every other event.
    assign redir           = redirect && (state != HALT);
    assign imem_req_valid  = rst && (state == RUN) &&
                             (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr   = fetch_pc;
    assign accept          = imem_req_valid && imem_req_ready;
    assign instr_valid     = (count != '0) && (state != HALT);
    assign pop             = instr_valid && !stall && !redir;
    assign push            = imem_resp_valid && !redir && (state != HALT) && (drop_cnt == '0);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_resp_valid);
    assign instr           = head[63:32];
    assign instr_pc        = head[31:0];

    // PCs of accepted requests; its occupancy is the outstanding-fetch count.
    fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (accept),
        .push_dat (fetch_pc),
        .pop      (imem_resp_valid),
        .head_dat (resp_pc),
        .count    (outstanding)
    );

    fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redir),
        .push     (push),
        .push_dat ({imem_resp_instr, resp_pc}),
        .pop      (pop),
        .head_dat (head),
        .count    (count)
    );

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        drop_cnt_nxt = drop_cnt;
        halted_nxt   = halted;
        case (state)
            RUN, DRAIN: begin
                if (redir) begin
                    fetch_pc_nxt = redirect_pc;
                    drop_cnt_nxt = outstanding_nxt;
                    state_nxt    = (outstanding_nxt != '0) ? DRAIN : RUN;
                end else begin
                    if (accept) fetch_pc_nxt = fetch_pc + 32'd4;
                    if (imem_resp_valid && (drop_cnt != '0)) begin
                        drop_cnt_nxt = drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) state_nxt = RUN;
                    end
                    if (pop && (head[63:32] == EBREAK)) begin
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            drop_cnt <= drop_cnt_nxt;
            halted   <= halted_nxt;
        end
    end
endmodule
